// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a RISC-V core and the data-memory controller.
// The core drives the request side. The controller returns a one-cycle response pulse.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory controller: byte/half/word loads and stores with alignment,
// range and funct3 checking, and a configurable number of wait states.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          in_range;
  logic [31:0]   lane_data;
  logic          bad_funct3;
  logic          misaligned;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic          mem_we;

  // The offset wraps, so addresses below BASE_ADDR become huge and fail the range test.
  assign off       = addr_q - BASE_ADDR;
  assign word_idx  = off[2 +: AW];
  assign lane      = off[1:0];
  assign in_range  = off < SPAN;
  assign lane_data = mem_q[word_idx] >> {lane, 3'b000};

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    bad_funct3 = 1'b0;
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata_rep  = '0;
    rdata_d    = '0;
    case (funct3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        be         = 4'b0011 << lane;
        wdata_rep  = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        misaligned = |lane;
        be         = 4'b1111;
        wdata_rep  = wdata_q;
      end
      default: bad_funct3 = 1'b1;
    endcase
    // Stores have no unsigned forms; loads have no 110.
    if (we_q ? funct3_q[2] : (funct3_q == 3'b110)) bad_funct3 = 1'b1;
    err_d = bad_funct3 || misaligned || !in_range;
    if (!we_q && !err_d) begin
      case (funct3_q)
        F3_B:    rdata_d = {{24{lane_data[7]}}, lane_data[7:0]};
        F3_H:    rdata_d = {{16{lane_data[15]}}, lane_data[15:0]};
        F3_W:    rdata_d = lane_data;
        F3_BU:   rdata_d = {24'h0, lane_data[7:0]};
        F3_HU:   rdata_d = {16'h0, lane_data[15:0]};
        default: rdata_d = '0;
      endcase
    end
  end

  // A store whose final edge coincides with reset is dropped.
  assign mem_we = (state_q == ST_ACCESS) && reset && we_q && !err_d;

  // NOTE: the storage array has no reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (WAIT_STATES == 0) begin
              state_q <= ST_ACCESS;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_d;
          rsp_err_q   <= err_d;
          state_q     <= ST_RESP;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) && reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) checked every cycle
// against a byte-addressed memory model with per-request response timing.
module tb_data_mem_ctrl;
  localparam int          DW    = 16;
  localparam int          NB    = 4 * DW;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0000_0100;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if if0();
  data_mem_ctrl_if if3();

  data_mem_ctrl #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  data_mem_ctrl #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  typedef struct {
    int          acc;
    int          due;
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          off;
    int          size;
    logic [31:0] wd;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mm [2][NB];
  int         free_c [2] = '{0, 0};
  int         last_rsp [2] = '{-1, -1};
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: a flat byte array plus the RV32I access rules.
  function automatic void predict(input int d, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output exp_t e);
    logic [31:0] off;
    int          size;
    logic [31:0] v;
    off  = addr - ((d == 0) ? BASE0 : BASE3);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e.we    = we;
    e.wd    = wd;
    e.size  = size;
    e.err   = (off >= 32'(NB)) || (f3[1:0] == 2'b11) || (we && f3[2]) ||
              (!we && f3 == 3'b110) || ((off % size) != 0);
    e.off   = e.err ? 0 : int'(off);
    e.rdata = '0;
    e.acc   = 0;
    e.due   = 0;
    if (!we && !e.err) begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(mm[d][e.off + i]) << (8 * i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      e.rdata = v;
    end
  endfunction

  task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_funct3 = f3;
      if0.req_addr = addr; if0.req_wdata = wd;
    end else begin
      if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3;
      if3.req_addr = addr; if3.req_wdata = wd;
    end
  endtask

  // Presents one request when the model says the controller is idle; hold keeps
  // req_valid asserted for extra cycles after acceptance.
  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output exp_t e);
    int w;
    w = (d == 0) ? 0 : 3;
    @(negedge clk);
    while (cyc < free_c[d]) @(negedge clk);
    predict(d, we, f3, addr, wd, e);
    e.acc     = cyc + 1;
    e.due     = e.acc + 1 + w;
    free_c[d] = e.acc + 2 + w;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive(d, 1'b1, we, f3, addr, wd);
    @(negedge clk);
    while (cyc < e.acc + hold) @(negedge clk);
    drive(d, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic wait_rsp(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check($sformatf("rsp_timeout[%0d]", d), 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  task automatic pin(input string name, input exp_t e, input logic [31:0] rd, input logic er);
    check({name, "_rdata"}, e.rdata, rd);
    check({name, "_err"}, 32'(e.err), 32'(er));
  endtask

  task automatic compare(input int d, input logic rdy, input logic v,
                         input logic [31:0] rd, input logic er);
    exp_t e;
    bit   exp_v;
    exp_v = 1'b0;
    if (d == 0) begin
      if (q0.size() != 0) begin e = q0[0]; exp_v = (e.due == cyc); end
    end else begin
      if (q1.size() != 0) begin e = q1[0]; exp_v = (e.due == cyc); end
    end
    check($sformatf("ready[%0d]@%0d", d, cyc), 32'(rdy), 32'(reset && (cyc >= free_c[d])));
    check($sformatf("rsp_valid[%0d]@%0d", d, cyc), 32'(v), 32'(exp_v));
    check($sformatf("rsp_rdata[%0d]@%0d", d, cyc), rd, exp_v ? e.rdata : 32'h0);
    check($sformatf("rsp_err[%0d]@%0d", d, cyc), 32'(er), exp_v ? 32'(e.err) : 32'h0);
    if (exp_v) begin
      if (e.we && !e.err)
        for (int i = 0; i < e.size; i++) mm[d][e.off + i] = e.wd[8*i +: 8];
      last_rsp[d] = cyc;
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  // Single compare process: model reset bookkeeping, then sample just after the edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      q0.delete();
      q1.delete();
      free_c[0] = cyc;
      free_c[1] = cyc;
    end
    #1;
    compare(0, if0.req_ready, if0.rsp_valid, if0.rsp_rdata, if0.rsp_err);
    compare(1, if3.req_ready, if3.rsp_valid, if3.rsp_rdata, if3.rsp_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] old;
    logic [31:0] off;
    int          d;
    int          r;

    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Give every word a defined value.
    for (int w = 0; w < DW; w++) begin
      issue(0, 1'b1, LW, BASE0 + 32'(4 * w), $urandom, 0, e);
      issue(1, 1'b1, LW, BASE3 + 32'(4 * w), $urandom, 0, e);
    end
    wait_rsp(0);
    wait_rsp(1);

    // Word store/load with single-cycle access.
    issue(0, 1'b1, LW, 32'h10, 32'hDEAD_BEEF, 0, e); pin("t1_sw", e, 32'h0, 1'b0);
    issue(0, 1'b0, LW, 32'h10, 32'h0, 0, e);         pin("t1_lw", e, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(0);
    check("t1_latency", 32'(last_rsp[0]), 32'(e.acc + 1));

    // Byte store and signed/unsigned byte loads.
    issue(0, 1'b1, LB, 32'h13, 32'h0000_0080, 0, e); pin("t2_sb", e, 32'h0, 1'b0);
    issue(0, 1'b0, LB, 32'h13, 32'h0, 0, e);         pin("t2_lb", e, 32'hFFFF_FF80, 1'b0);
    issue(0, 1'b0, LBU, 32'h13, 32'h0, 0, e);        pin("t2_lbu", e, 32'h0000_0080, 1'b0);
    issue(0, 1'b0, LW, 32'h10, 32'h0, 0, e);         pin("t2_lw", e, 32'h80AD_BEEF, 1'b0);

    // Half-word stores and loads.
    issue(0, 1'b1, LH, 32'h12, 32'h0000_1234, 0, e); pin("t3_sh_hi", e, 32'h0, 1'b0);
    issue(0, 1'b0, LW, 32'h10, 32'h0, 0, e);         pin("t3_lw_a", e, 32'h1234_BEEF, 1'b0);
    issue(0, 1'b0, LH, 32'h12, 32'h0, 0, e);         pin("t3_lh_hi", e, 32'h0000_1234, 1'b0);
    issue(0, 1'b1, LH, 32'h10, 32'h0000_8001, 0, e); pin("t3_sh_lo", e, 32'h0, 1'b0);
    issue(0, 1'b0, LH, 32'h10, 32'h0, 0, e);         pin("t3_lh_lo", e, 32'hFFFF_8001, 1'b0);
    issue(0, 1'b0, LHU, 32'h10, 32'h0, 0, e);        pin("t3_lhu_lo", e, 32'h0000_8001, 1'b0);

    // Error cases, plus the first-legal/last-legal word boundary.
    issue(0, 1'b0, LW, 32'h11, 32'h0, 0, e);         pin("t4_lw_mis", e, 32'h0, 1'b1);
    issue(0, 1'b1, LW, 32'h12, 32'h5555_5555, 0, e); pin("t4_sw_mis", e, 32'h0, 1'b1);
    issue(0, 1'b0, LW, 32'h10, 32'h0, 0, e);         pin("t4_lw_same", e, 32'h1234_8001, 1'b0);
    issue(0, 1'b0, LW, 32'(NB), 32'h0, 0, e);        pin("t4_lw_oor", e, 32'h0, 1'b1);
    issue(0, 1'b0, 3'b011, 32'h10, 32'h0, 0, e);     pin("t4_f3_011", e, 32'h0, 1'b1);
    issue(0, 1'b1, 3'b100, 32'h10, 32'h0, 0, e);     pin("t4_sf3_100", e, 32'h0, 1'b1);
    issue(0, 1'b0, LW, 32'(NB - 4), 32'h0, 0, e);    check("t4_last_err", 32'(e.err), 32'h0);
    issue(1, 1'b0, LW, BASE3 - 32'h4, 32'h0, 0, e);  pin("t4_below_base", e, 32'h0, 1'b1);
    wait_rsp(0);
    wait_rsp(1);

    // Three wait states with req_valid held through the busy period.
    issue(1, 1'b1, LW, BASE3 + 32'h24, 32'h1357_9BDF, 4, e);
    wait_rsp(1);
    check("t5_latency", 32'(last_rsp[1]), 32'(e.acc + 4));
    issue(1, 1'b0, LW, BASE3 + 32'h24, 32'h0, 0, e); pin("t5_lw", e, 32'h1357_9BDF, 1'b0);
    wait_rsp(1);

    // Reset during WAIT aborts the store without a response.
    issue(1, 1'b0, LW, BASE3 + 32'h20, 32'h0, 0, e);
    old = e.rdata;
    wait_rsp(1);
    issue(1, 1'b1, LW, BASE3 + 32'h20, 32'hA5A5_A5A5, 0, e);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_ready_after_reset", 32'(if3.req_ready), 32'h1);
    repeat (6) @(negedge clk);
    check("t6_no_rsp", 32'(last_rsp[1] > e.acc), 32'h0);
    issue(1, 1'b0, LW, BASE3 + 32'h20, 32'h0, 0, e); pin("t6_lw_old", e, old, 1'b0);
    wait_rsp(1);

    // Randomised mix across both instances.
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)      off = 32'(NB) + $urandom_range(0, 15);
      else if (r == 1) off = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else             off = $urandom_range(0, NB - 1);
      issue(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ((d == 0) ? BASE0 : BASE3) + off, $urandom, 0, e);
    end
    wait_rsp(0);
    wait_rsp(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
